// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes rows, debounces press/release, presents the held key one-hot.
// Optional build macro KEYPAD_SCAN_MULTIKEY_REJECT_EN rejects chorded/ghosted multi-column samples.
module keypad_scanner #(
  parameter int SCAN_DIV        = 100000,
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] rows,
  output logic [3:0] columns,
  output logic       key_valid,
  output logic       key_pulse
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST    = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_PRESS_END = BW'(DEBOUNCE_CYCLES - 1);
  // The HELD cycle that first sees the release counts toward the release window.
  localparam logic [BW-1:0] DEB_REL_END   = BW'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  function automatic logic [3:0] lowest_bit(input logic [3:0] v);
    return v & (~v + 4'd1);
  endfunction

  function automatic logic multi_bit(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction

  state_t          state_q, state_d;
  logic [3:0]      meta_q, sync_q;
  logic [1:0]      idx_q, idx_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [BW-1:0]   deb_q, deb_d;
  logic [3:0]      cap_q, cap_d;
  logic [3:0]      row_n_q;
  logic [3:0]      rows_q, rows_d;
  logic [3:0]      columns_q, columns_d;
  logic            valid_q, valid_d;
  logic            pulse_q, pulse_d;

  logic [3:0]      col_s;
  logic            hit_s;
  logic            press_ok_s;
  logic            sample_ok_s;

  assign col_s = ~sync_q;
  assign hit_s = (col_s & cap_q) != 4'd0;

`ifdef KEYPAD_SCAN_MULTIKEY_REJECT_EN
  assign press_ok_s  = hit_s && ((col_s & ~cap_q) == 4'd0);
  assign sample_ok_s = (col_s != 4'd0) && !multi_bit(col_s);
`else
  assign press_ok_s  = hit_s;
  assign sample_ok_s = (col_s != 4'd0);
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dwell_d   = dwell_q;
    deb_d     = deb_q;
    cap_d     = cap_q;
    rows_d    = rows_q;
    columns_d = columns_q;
    valid_d   = valid_q;
    pulse_d   = 1'b0;
    case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          if (sample_ok_s) begin
            cap_d   = lowest_bit(col_s);
            deb_d   = '0;
            state_d = DB_PRESS;
          end else begin
            idx_d   = idx_q + 2'd1;
            dwell_d = '0;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      DB_PRESS: begin
        if (press_ok_s) begin
          if (deb_q == DEB_PRESS_END) begin
            state_d   = HELD;
            rows_d    = 4'b0001 << idx_q;
            columns_d = cap_q;
            valid_d   = 1'b1;
            pulse_d   = 1'b1;
          end else begin
            deb_d = deb_q + BW'(1);
          end
        end else begin
          idx_d   = idx_q + 2'd1;
          dwell_d = '0;
          state_d = SCAN;
        end
      end
      HELD: begin
        if (hit_s) begin
          state_d = HELD;
        end else begin
          deb_d   = '0;
          state_d = DB_RELEASE;
        end
      end
      DB_RELEASE: begin
        if (hit_s) begin
          state_d = HELD;
        end else if (deb_q == DEB_REL_END) begin
          rows_d    = 4'd0;
          columns_d = 4'd0;
          valid_d   = 1'b0;
          idx_d     = idx_q + 2'd1;
          dwell_d   = '0;
          state_d   = SCAN;
        end else begin
          deb_d = deb_q + BW'(1);
        end
      end
      default: begin
        state_d = SCAN;
      end
    endcase
  end

  // State, counters, synchronizer and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SCAN;
      meta_q    <= 4'hF;
      sync_q    <= 4'hF;
      idx_q     <= 2'd0;
      dwell_q   <= '0;
      deb_q     <= '0;
      cap_q     <= 4'd0;
      row_n_q   <= 4'b1110;
      rows_q    <= 4'd0;
      columns_q <= 4'd0;
      valid_q   <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      meta_q    <= col_n;
      sync_q    <= meta_q;
      idx_q     <= idx_d;
      dwell_q   <= dwell_d;
      deb_q     <= deb_d;
      cap_q     <= cap_d;
      row_n_q   <= ~(4'b0001 << idx_d);
      rows_q    <= rows_d;
      columns_q <= columns_d;
      valid_q   <= valid_d;
      pulse_q   <= pulse_d;
    end
  end

  assign row_n     = row_n_q;
  assign rows      = rows_q;
  assign columns   = columns_q;
  assign key_valid = valid_q;
  assign key_pulse = pulse_q;

endmodule
